// File: rtl/pipe_ex_mem_reg.sv
// EX/MEM pipeline register: captures the execute-stage result, store data,
// destination register and memory/write-back control flags on every clock edge.
module pipe_ex_mem_reg #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             MEMWRITE_IN,
  input  logic             MEMTOREG_IN,
  input  logic             REGWRITE_IN,
  input  logic [WIDTH-1:0] RESULTOP_IN,
  input  logic [WIDTH-1:0] WRDATA_IN,
  input  logic [4:0]       ARD_IN,
  output logic             MEMWRITE_OUT,
  output logic             MEMTOREG_OUT,
  output logic             REGWRITE_OUT,
  output logic [WIDTH-1:0] RESULTOP_OUT,
  output logic [WIDTH-1:0] WRDATA_OUT,
  output logic [4:0]       ARD_OUT
);

  logic             memwrite_reg;
  logic             memtoreg_reg;
  logic             regwrite_reg;
  logic [WIDTH-1:0] resultop_reg;
  logic [WIDTH-1:0] wrdata_reg;
  logic [4:0]       ard_reg;

  // A cleared stage is a bubble: no memory write and no register write.
  always_ff @(posedge clk) begin
    if (!rst) begin
      memwrite_reg <= 1'b0;
      memtoreg_reg <= 1'b0;
      regwrite_reg <= 1'b0;
      resultop_reg <= '0;
      wrdata_reg   <= '0;
      ard_reg      <= '0;
    end else begin
      memwrite_reg <= MEMWRITE_IN;
      memtoreg_reg <= MEMTOREG_IN;
      regwrite_reg <= REGWRITE_IN;
      resultop_reg <= RESULTOP_IN;
      wrdata_reg   <= WRDATA_IN;
      ard_reg      <= ARD_IN;
    end
  end

  assign MEMWRITE_OUT = memwrite_reg;
  assign MEMTOREG_OUT = memtoreg_reg;
  assign REGWRITE_OUT = regwrite_reg;
  assign RESULTOP_OUT = resultop_reg;
  assign WRDATA_OUT   = wrdata_reg;
  assign ARD_OUT      = ard_reg;

endmodule

// File: tb/tb_pipe_ex_mem_reg.sv
// Directed bench for the EX/MEM pipeline register: reset, load, back-to-back
// updates, mid-stream reset, between-edge reset pulses and walking-one fields.
module tb_pipe_ex_mem_reg;

  localparam int WIDTH = 32;

  logic             clk;
  logic             rst;
  logic             mw_in, mt_in, rw_in;
  logic [WIDTH-1:0] res_in, wd_in;
  logic [4:0]       ard_in;
  logic             mw_out, mt_out, rw_out;
  logic [WIDTH-1:0] res_out, wd_out;
  logic [4:0]       ard_out;

  int pass_cnt  = 0;
  int check_cnt = 0;

  pipe_ex_mem_reg #(.WIDTH(WIDTH)) dut (
    .clk          (clk),
    .rst          (rst),
    .MEMWRITE_IN  (mw_in),
    .MEMTOREG_IN  (mt_in),
    .REGWRITE_IN  (rw_in),
    .RESULTOP_IN  (res_in),
    .WRDATA_IN    (wd_in),
    .ARD_IN       (ard_in),
    .MEMWRITE_OUT (mw_out),
    .MEMTOREG_OUT (mt_out),
    .REGWRITE_OUT (rw_out),
    .RESULTOP_OUT (res_out),
    .WRDATA_OUT   (wd_out),
    .ARD_OUT      (ard_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    check_cnt++;
    if (obs === expv) pass_cnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, expv);
  endtask

  task automatic drive(input logic r, input logic mw, input logic mt, input logic rw,
                       input logic [WIDTH-1:0] res, input logic [WIDTH-1:0] wd,
                       input logic [4:0] ard);
    rst = r; mw_in = mw; mt_in = mt; rw_in = rw;
    res_in = res; wd_in = wd; ard_in = ard;
  endtask

  task automatic check_all(input string tag, input logic mw, input logic mt, input logic rw,
                           input logic [WIDTH-1:0] res, input logic [WIDTH-1:0] wd,
                           input logic [4:0] ard);
    $display("%s: mw=%0b mt=%0b rw=%0b res=%08h wd=%08h ard=%02h", tag,
             mw_out, mt_out, rw_out, res_out, wd_out, ard_out);
    check_val({tag, ".memwrite"}, 64'(mw_out),  64'(mw));
    check_val({tag, ".memtoreg"}, 64'(mt_out),  64'(mt));
    check_val({tag, ".regwrite"}, 64'(rw_out),  64'(rw));
    check_val({tag, ".resultop"}, 64'(res_out), 64'(res));
    check_val({tag, ".wrdata"},   64'(wd_out),  64'(wd));
    check_val({tag, ".ard"},      64'(ard_out), 64'(ard));
  endtask

  // Drive at the falling edge, let one rising edge pass, sample 1 time unit later.
  task automatic step(input string tag, input logic r, input logic mw, input logic mt,
                      input logic rw, input logic [WIDTH-1:0] res,
                      input logic [WIDTH-1:0] wd, input logic [4:0] ard,
                      input logic emw, input logic emt, input logic erw,
                      input logic [WIDTH-1:0] eres, input logic [WIDTH-1:0] ewd,
                      input logic [4:0] eard);
    @(negedge clk);
    drive(r, mw, mt, rw, res, wd, ard);
    @(posedge clk);
    #1;
    check_all(tag, emw, emt, erw, eres, ewd, eard);
  endtask

  initial begin
    drive(1'b0, 1'b1, 1'b1, 1'b1, 32'hDEADBEEF, 32'hCAFEF00D, 5'd31);

    // Reset with non-zero inputs present
    step("reset", 1'b0, 1'b1, 1'b1, 1'b1, 32'hDEADBEEF, 32'hCAFEF00D, 5'd31,
         1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);

    step("load", 1'b1, 1'b1, 1'b1, 1'b1, 32'hA5A5A5A5, 32'h55555555, 5'b10101,
         1'b1, 1'b1, 1'b1, 32'hA5A5A5A5, 32'h55555555, 5'b10101);

    step("b2b", 1'b1, 1'b0, 1'b1, 1'b0, 32'h12345678, 32'h87654321, 5'b01010,
         1'b0, 1'b1, 1'b0, 32'h12345678, 32'h87654321, 5'b01010);

    step("midrst", 1'b0, 1'b1, 1'b0, 1'b1, 32'h0BADF00D, 32'hFEEDFACE, 5'd7,
         1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);

    step("reload", 1'b1, 1'b1, 1'b0, 1'b1, 32'h0BADF00D, 32'hFEEDFACE, 5'd7,
         1'b1, 1'b0, 1'b1, 32'h0BADF00D, 32'hFEEDFACE, 5'd7);

    // Reset pulsed low and inputs changed between edges: outputs must hold
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b1, 1'b0, 32'h11111111, 32'h22222222, 5'd3);
    #2;
    drive(1'b1, 1'b0, 1'b1, 1'b0, 32'h33333333, 32'h44444444, 5'd9);
    #1;
    check_all("between", 1'b1, 1'b0, 1'b1, 32'h0BADF00D, 32'hFEEDFACE, 5'd7);
    @(posedge clk);
    #1;
    check_all("sampled", 1'b0, 1'b1, 1'b0, 32'h33333333, 32'h44444444, 5'd9);

    // Walking ones, everything else zero
    for (int i = 0; i < WIDTH; i++) begin
      step($sformatf("walk_res%0d", i), 1'b1, 1'b0, 1'b0, 1'b0, 32'h1 << i, 32'h0, 5'd0,
           1'b0, 1'b0, 1'b0, 32'h1 << i, 32'h0, 5'd0);
    end
    for (int i = 0; i < WIDTH; i++) begin
      step($sformatf("walk_wd%0d", i), 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h1 << i, 5'd0,
           1'b0, 1'b0, 1'b0, 32'h0, 32'h1 << i, 5'd0);
    end
    for (int i = 0; i < 5; i++) begin
      step($sformatf("walk_ard%0d", i), 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'(1 << i),
           1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'(1 << i));
    end
    step("flag_mw", 1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0,
         1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
    step("flag_mt", 1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 32'h0, 5'd0,
         1'b0, 1'b1, 1'b0, 32'h0, 32'h0, 5'd0);
    step("flag_rw", 1'b1, 1'b0, 1'b0, 1'b1, 32'h0, 32'h0, 5'd0,
         1'b0, 1'b0, 1'b1, 32'h0, 32'h0, 5'd0);

    step("ones", 1'b1, 1'b1, 1'b1, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'b11111,
         1'b1, 1'b1, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'b11111);

    step("rst_ones", 1'b0, 1'b1, 1'b1, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'b11111,
         1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);

    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
